result_formatter: RTL and testbench
===================================

RESULT_FORMATTER -- requirements
Module: result_formatter

Interface
REQ-001 Parameter SIGNED, default 1: 1 treats res_value as two's complement; 0 treats it as unsigned.
REQ-002 Parameter EOL_CRLF, default 1: 1 terminates each line with CR LF; 0 terminates with LF only.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 res_ready  input  1  one-cycle strobe marking res_value valid (driven by the rpn stage).
REQ-006 res_value  input  16  result to print.
REQ-007 tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-008 tx_valid  output  1  tx_data holds a valid byte.
REQ-009 tx_ready  input  1  the transmitter accepts a byte this cycle.
REQ-010 busy  output  1  a result is being converted or emitted.
REQ-011 dropped  output  1  one-cycle pulse when a res_ready strobe is ignored.

Function
REQ-012 The block SHALL capture res_value on a cycle with res_ready=1 and busy=0, and SHALL assert busy from the next cycle.
REQ-013 Capture SHALL form sign = SIGNED & res_value[15] and magnitude = (sign ? 0 - res_value : res_value) as 16-bit unsigned, so 0x8000 yields 32768.
REQ-014 The FSM SHALL use the states IDLE, CONV, SIGN, DIGIT, CR, LF.
REQ-015 CONV SHALL extract five decimal digits by repeated subtraction of 10000, 1000, 100, 10, 1: one subtraction per cycle while remainder >= power, then one cycle to advance to the next power.
REQ-016 After CONV the FSM SHALL go to SIGN if sign=1, else to DIGIT.
REQ-017 DIGIT SHALL emit digits from the most significant non-zero digit through the units digit, keeping interior zeros; a zero magnitude SHALL emit a single '0' (0x30).
REQ-018 SIGN SHALL emit '-' (0x2D).
REQ-019 After the units digit the FSM SHALL go to CR (0x0D) and then LF (0x0A) if EOL_CRLF=1, else directly to LF, and then to IDLE.
REQ-020 tx_valid SHALL be high in SIGN, DIGIT, CR and LF only.
REQ-021 A byte SHALL transfer on a cycle with tx_valid=1 and tx_ready=1.
REQ-022 tx_data and tx_valid SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-023 The next byte SHALL be presented in the cycle after a transfer, allowing one byte per cycle with tx_ready held high.
REQ-024 The first tx_valid SHALL rise no later than 48 cycles after the capture edge.
REQ-025 busy SHALL fall in the cycle after the LF transfer.
REQ-026 A res_ready strobe while busy=1, including the cycle of the LF transfer, SHALL be ignored, SHALL leave the byte stream unchanged, and SHALL pulse dropped for exactly one cycle in the following cycle.
REQ-027 tx_data SHALL read 0x00 whenever tx_valid=0.

Reset
REQ-028 With rst=1 at a clock edge, the FSM SHALL enter IDLE, and tx_valid, busy and dropped SHALL be 0 and tx_data 0x00 after that edge.
REQ-029 Reset SHALL abort any conversion or emission in progress; no partial line SHALL resume after rst falls.
REQ-030 rst SHALL take priority over a simultaneous res_ready, and that strobe SHALL not be captured.

Structure
REQ-031 Shared package rpn_pkg SHALL hold the ASCII constants (0x30, 0x2D, 0x0D, 0x0A), the power-of-ten table and the formatter state enum.
REQ-032 Digit extraction SHALL be a sub-module, bcd_extract (start/done handshake, 16-bit in, 5x4-bit out), instantiated once.

Verification
REQ-033 Send res_value=0x0000 with tx_ready=1 -> bytes 30 0D 0A, then busy=0.
REQ-034 Send res_value=0x3039 -> bytes 31 32 33 34 35 0D 0A; send 0x0064 -> bytes 31 30 30 0D 0A.
REQ-035 Send 0x8000 and 0xFFFF with SIGNED=1 -> bytes 2D 33 32 37 36 38 0D 0A and 2D 31 0D 0A; send 0x8000 with SIGNED=0 -> bytes 33 32 37 36 38 0D 0A; EOL_CRLF=0 omits the 0D byte.
REQ-036 Send 12345, hold tx_ready=0 for 20 cycles, then toggle tx_ready randomly -> tx_data stable while stalled and the full byte stream intact; a second res_ready mid-line -> one dropped pulse with the stream unchanged.
REQ-037 Assert rst during the third byte of 12345 -> tx_valid=0 and busy=0 after that edge; then send 0x0007 -> bytes 37 0D 0A only.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared constants and types for the calculator output path: ASCII codes,
// decimal place weights and the result formatter state encoding.
package rpn_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int NUM_DIGITS = 5;

    // POW10[k] is the weight of decimal place k, so place 4 is the leading digit.
    localparam logic [4:0][15:0] POW10 = {16'd10000, 16'd1000, 16'd100, 16'd10, 16'd1};

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SIGN,
        DIGIT,
        CR,
        LF
    } fmt_state_e;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_ZERO | {4'h0, d};
    endfunction

endpackage

// File: rtl/result_formatter_bcd.sv
// Binary to five-digit BCD by repeated subtraction of place weights; start
// loads a new value, done pulses for one cycle once every place is settled.
module bcd_extract
    import rpn_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [15:0]     value_i,
    output logic            done_o,
    output logic [4:0][3:0] digits_o
);

    logic            active_q, active_d;
    logic [15:0]     rem_q, rem_d;
    logic [2:0]      place_q, place_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [4:0][3:0] digits_q, digits_d;
    logic            done_q, done_d;

    always_comb begin
        active_d = active_q;
        rem_d    = rem_q;
        place_d  = place_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        done_d   = 1'b0;
        if (start_i) begin
            active_d = 1'b1;
            rem_d    = value_i;
            place_d  = 3'd4;
            cnt_d    = 4'd0;
        end else if (active_q) begin
            if (rem_q >= POW10[place_q]) begin
                rem_d = rem_q - POW10[place_q];
                cnt_d = cnt_q + 4'd1;
            end else begin
                // Remainder below this weight: the count is final for this place.
                digits_d[place_q] = cnt_q;
                cnt_d = 4'd0;
                if (place_q == 3'd0) begin
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    place_d = place_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            rem_q    <= '0;
            place_q  <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            rem_q    <= rem_d;
            place_q  <= place_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            done_q   <= done_d;
        end
    end

    assign done_o   = done_q;
    assign digits_o = digits_q;

endmodule

// File: rtl/result_formatter.sv
// Turns a 16-bit result into an ASCII decimal line (optional '-', digits,
// CR/LF) and streams it one byte at a time over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for res_ready; tx_valid low
// CONV  | bcd_extract running on the captured magnitude
// SIGN  | offering '-'
// DIGIT | offering digits from the leading non-zero one down to the units
// CR    | offering carriage return
// LF    | offering line feed; line ends when it transfers
module result_formatter
    import rpn_pkg::*;
#(
    parameter int SIGNED   = 1,
    parameter int EOL_CRLF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_ready,
    input  logic [15:0] res_value,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        dropped
);

    fmt_state_e      state_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            busy_q;
    logic            dropped_q;
    logic            sign_q;
    logic [2:0]      idx_q;

    logic            cap_sign;
    logic [15:0]     magnitude;
    logic            capture;
    logic            bcd_done;
    logic [4:0][3:0] digits;
    logic [2:0]      lead;

    assign cap_sign  = (SIGNED != 0) && res_value[15];
    assign magnitude = cap_sign ? (16'd0 - res_value) : res_value;
    assign capture   = (state_q == IDLE) && res_ready;

    bcd_extract u_bcd (
        .clk      (clk),
        .rst      (rst),
        .start_i  (capture),
        .value_i  (magnitude),
        .done_o   (bcd_done),
        .digits_o (digits)
    );

    // Highest non-zero place; a zero magnitude falls back to the units place.
    always_comb begin
        lead = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digits[k] != 4'd0) lead = 3'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            dropped_q  <= 1'b0;
            sign_q     <= 1'b0;
            idx_q      <= '0;
        end else begin
            dropped_q <= res_ready && busy_q;
            case (state_q)
                IDLE: begin
                    if (res_ready) begin
                        sign_q  <= cap_sign;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    if (bcd_done) begin
                        idx_q      <= lead;
                        tx_valid_q <= 1'b1;
                        if (sign_q) begin
                            state_q   <= SIGN;
                            tx_data_q <= ASCII_MINUS;
                        end else begin
                            state_q   <= DIGIT;
                            tx_data_q <= digit_ascii(digits[lead]);
                        end
                    end
                end
                SIGN: begin
                    if (tx_ready) begin
                        state_q   <= DIGIT;
                        tx_data_q <= digit_ascii(digits[idx_q]);
                    end
                end
                DIGIT: begin
                    if (tx_ready) begin
                        if (idx_q == 3'd0) begin
                            if (EOL_CRLF != 0) begin
                                state_q   <= CR;
                                tx_data_q <= ASCII_CR;
                            end else begin
                                state_q   <= LF;
                                tx_data_q <= ASCII_LF;
                            end
                        end else begin
                            idx_q     <= idx_q - 3'd1;
                            tx_data_q <= digit_ascii(digits[idx_q - 3'd1]);
                        end
                    end
                end
                CR: begin
                    if (tx_ready) begin
                        state_q   <= LF;
                        tx_data_q <= ASCII_LF;
                    end
                end
                LF: begin
                    if (tx_ready) begin
                        state_q    <= IDLE;
                        tx_data_q  <= 8'h00;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_data_q  <= 8'h00;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_result_formatter.sv
// Directed bench for result_formatter: three parameter variants share one
// stimulus; vector table plus stall, drop and reset sequences.
module tb_result_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_ready;
    logic [15:0] res_value;
    logic        tx_ready;

    logic [7:0]  td [3];
    logic        tv [3];
    logic        bz [3];
    logic        dr [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    result_formatter #(.SIGNED(1), .EOL_CRLF(1)) dut_s (
        .clk(clk), .rst(rst), .res_ready(res_ready), .res_value(res_value),
        .tx_data(td[0]), .tx_valid(tv[0]), .tx_ready(tx_ready), .busy(bz[0]), .dropped(dr[0]));

    result_formatter #(.SIGNED(0), .EOL_CRLF(1)) dut_u (
        .clk(clk), .rst(rst), .res_ready(res_ready), .res_value(res_value),
        .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(tx_ready), .busy(bz[1]), .dropped(dr[1]));

    result_formatter #(.SIGNED(1), .EOL_CRLF(0)) dut_lf (
        .clk(clk), .rst(rst), .res_ready(res_ready), .res_value(res_value),
        .tx_data(td[2]), .tx_valid(tv[2]), .tx_ready(tx_ready), .busy(bz[2]), .dropped(dr[2]));

    typedef struct {
        logic [15:0] val;
        int          sel;
        int          n;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_all_idle();
        tx_ready  = 1'b1;
        res_ready = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!bz[0] && !bz[1] && !bz[2]) break;
            @(negedge clk);
        end
        check("all_idle", {29'd0, bz[0], bz[1], bz[2]}, 32'd0);
    endtask

    task automatic run_vec(input int id, input int sel, input logic [15:0] val,
                           input int n, input logic [63:0] exp);
        logic [7:0] bytes [8];
        int got = 0;
        int first = -1;
        logic zero_ok = 1'b1;
        res_value = val;
        res_ready = 1'b1;
        tx_ready  = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (tv[sel]) begin
                if (first < 0) first = cyc;
                if (got < 8) bytes[got] = td[sel];
                got++;
            end else if (td[sel] != 8'h00) begin
                zero_ok = 1'b0;
            end
            if (!bz[sel]) break;
            @(negedge clk);
        end
        check($sformatf("v%0d_busy_low", id), {31'd0, bz[sel]}, 32'd0);
        check($sformatf("v%0d_count", id), got, n);
        for (int i = 0; i < n && i < 8; i++)
            check($sformatf("v%0d_byte%0d", id, i), {24'd0, bytes[i]}, {24'd0, exp[63-8*i -: 8]});
        check($sformatf("v%0d_idle_zero", id), {31'd0, zero_ok}, 32'd1);
        check($sformatf("v%0d_latency_ok", id), {31'd0, (first >= 0 && first <= 48)}, 32'd1);
        wait_all_idle();
    endtask

    task automatic stall_test();
        logic [7:0] bytes [8];
        logic [63:0] exp = 64'h31323334350D0A00;
        int got = 0;
        int drops = 0;
        logic hold_ok = 1'b1;
        logic stable_ok = 1'b1;
        logic drop_ok = 1'b1;
        logic mid_done = 1'b0;
        logic strobe_prev = 1'b0;
        logic prev_stalled = 1'b0;
        logic [7:0] prev_data = 8'h00;
        res_value = 16'd12345;
        res_ready = 1'b1;
        tx_ready  = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (tv[0]) break;
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            if (!(tv[0] && td[0] == 8'h31)) hold_ok = 1'b0;
            @(negedge clk);
        end
        check("stall_hold", {31'd0, hold_ok}, 32'd1);
        for (int c = 0; c < 400; c++) begin
            if (dr[0] !== strobe_prev) drop_ok = 1'b0;
            if (dr[0]) drops++;
            strobe_prev = 1'b0;
            res_ready   = 1'b0;
            if (!bz[0]) break;
            if (prev_stalled && !(tv[0] && td[0] == prev_data)) stable_ok = 1'b0;
            tx_ready = 1'($urandom_range(0, 1));
            if (tv[0] && tx_ready) begin
                if (got < 8) bytes[got] = td[0];
                got++;
                if (td[0] == 8'h0A) begin
                    res_value   = 16'h0007;
                    res_ready   = 1'b1;
                    strobe_prev = 1'b1;
                end
            end
            if (!mid_done && got == 2) begin
                mid_done    = 1'b1;
                res_value   = 16'h0007;
                res_ready   = 1'b1;
                strobe_prev = 1'b1;
            end
            prev_stalled = tv[0] && !tx_ready;
            prev_data    = td[0];
            @(negedge clk);
        end
        res_ready = 1'b0;
        tx_ready  = 1'b1;
        @(negedge clk);
        check("lf_strobe_not_captured", {31'd0, bz[0]}, 32'd0);
        check("dropped_single_cycle", {31'd0, dr[0]}, 32'd0);
        check("stall_stable", {31'd0, stable_ok}, 32'd1);
        check("drop_timing", {31'd0, drop_ok}, 32'd1);
        check("drop_pulses", drops, 2);
        check("stall_count", got, 7);
        for (int i = 0; i < 7; i++)
            check($sformatf("stall_byte%0d", i), {24'd0, bytes[i]}, {24'd0, exp[63-8*i -: 8]});
        wait_all_idle();
    endtask

    task automatic reset_test();
        int got = 0;
        res_value = 16'd12345;
        res_ready = 1'b1;
        tx_ready  = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (tv[0]) begin
                if (got == 2) break;
                got++;
            end
            @(negedge clk);
        end
        check("rst_third_byte", {24'd0, td[0]}, 32'h33);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, tv[0]}, 32'd0);
        check("rst_mid_busy", {31'd0, bz[0]}, 32'd0);
        check("rst_mid_data", {24'd0, td[0]}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("rst_no_resume", {31'd0, tv[0]}, 32'd0);
        run_vec(100, 0, 16'h0007, 3, 64'h370D0A0000000000);
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 0, 3, 64'h300D0A0000000000};
        vecs[1]  = '{16'h3039, 0, 7, 64'h31323334350D0A00};
        vecs[2]  = '{16'h0064, 0, 5, 64'h3130300D0A000000};
        vecs[3]  = '{16'h8000, 0, 8, 64'h2D33323736380D0A};
        vecs[4]  = '{16'hFFFF, 0, 4, 64'h2D310D0A00000000};
        vecs[5]  = '{16'h8000, 1, 7, 64'h33323736380D0A00};
        vecs[6]  = '{16'h0064, 2, 4, 64'h3130300A00000000};
        vecs[7]  = '{16'hFFFF, 1, 7, 64'h36353533350D0A00};
        vecs[8]  = '{16'hEA5F, 1, 7, 64'h35393939390D0A00};
        vecs[9]  = '{16'h8000, 2, 7, 64'h2D33323736380A00};
        vecs[10] = '{16'h000A, 0, 4, 64'h31300D0A00000000};
        vecs[11] = '{16'h03E8, 0, 6, 64'h313030300D0A0000};
        vecs[12] = '{16'hFFF6, 0, 5, 64'h2D31300D0A000000};

        rst       = 1'b1;
        res_ready = 1'b0;
        res_value = 16'h0000;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'd0, tv[0]}, 32'd0);
        check("reset_busy", {31'd0, bz[0]}, 32'd0);
        check("reset_dropped", {31'd0, dr[0]}, 32'd0);
        check("reset_data", {24'd0, td[0]}, 32'd0);

        res_ready = 1'b1;
        res_value = 16'h0005;
        @(negedge clk);
        rst       = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        check("rst_priority_busy", {31'd0, bz[0]}, 32'd0);
        check("rst_priority_valid", {31'd0, tv[0]}, 32'd0);
        check("rst_priority_dropped", {31'd0, dr[0]}, 32'd0);

        for (int v = 0; v < 13; v++)
            run_vec(v, vecs[v].sel, vecs[v].val, vecs[v].n, vecs[v].exp);

        stall_test();
        reset_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
